// File: rtl/icache_ctrl_if.sv
// Fetch-side and arbiter-side signal bundle for the instruction cache controller.
// The cache connects through the slave modport; the fetch stage and arbiter use master.
interface icache_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             imemREN;
  logic [31:0]      imemaddr;
  logic             ihit;
  logic [31:0]      imemload;
  logic             iREN;
  logic [31:0]      iaddr;
  logic             iwait;
  logic [31:0]      iload;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_cnt, miss_cnt
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped 16-frame, one-word-per-block instruction cache.
// Hits are answered in the same cycle; misses fill one word from the arbiter.
module icache_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic           CLK,
  input  logic           nRST,
  icache_ctrl_if.slave   bus
);
  localparam int unsigned TAG_W   = 26;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NFRAMES = 16;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              valid;
    logic [DATA_W-1:0] data;
  } icache_t;

  typedef enum logic {IDLE_I, LD} istate_t;

  icache_t          frame_q [NFRAMES];
  istate_t          state_q;
  logic             iren_q;
  logic [31:0]      iaddr_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_idx;
  logic             hit_c;
  logic [1:0]       unused_byte_ofs;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign unused_byte_ofs = bus.imemaddr[1:0];
  assign fill_tag        = iaddr_q[31:6];
  assign fill_idx        = iaddr_q[5:2];

  // Zero-latency tag compare; forced low while reset is asserted.
  always_comb begin
    req_tag = bus.imemaddr[31:6];
    req_idx = bus.imemaddr[5:2];
    hit_c   = 1'b0;
    if (nRST && (state_q == IDLE_I) && bus.imemREN &&
        frame_q[req_idx].valid && (frame_q[req_idx].tag == req_tag)) begin
      hit_c = 1'b1;
    end
  end

  assign bus.ihit     = hit_c;
  assign bus.imemload = hit_c ? frame_q[req_idx].data : '0;
  assign bus.iREN     = iren_q;
  assign bus.iaddr    = iaddr_q;
  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;

  // Fill FSM; reset abandons an in-flight fill and only clears valid bits.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE_I;
      iren_q     <= 1'b0;
      iaddr_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int i = 0; i < int'(NFRAMES); i++) begin
        frame_q[i].valid <= 1'b0;
      end
    end else begin
      case (state_q)
        IDLE_I: begin
          if (hit_c) begin
            hit_cnt_q <= sat_inc(hit_cnt_q);
          end else if (bus.imemREN) begin
            miss_cnt_q <= sat_inc(miss_cnt_q);
            iaddr_q    <= {bus.imemaddr[31:2], 2'b00};
            iren_q     <= 1'b1;
            state_q    <= LD;
          end
        end
        LD: begin
          if (!bus.iwait) begin
            frame_q[fill_idx] <= '{tag: fill_tag, valid: 1'b1, data: bus.iload};
            iren_q            <= 1'b0;
            iaddr_q           <= '0;
            state_q           <= IDLE_I;
          end
        end
        default: begin
          state_q <= IDLE_I;
          iren_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: random and directed fetches against a frame-level model.
module tb_icache_ctrl;
  logic CLK;
  logic nRST;

  icache_ctrl_if #(.CNT_W(32)) bus ();

  icache_ctrl #(.CNT_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what each frame should hold and the expected counters.
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  int unsigned m_hits;
  int unsigned m_miss;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_q [$];
  logic [31:0] exp_fill_addr;
  int          arb_lat;
  int          wcnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    bus.imemREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    model_reset();
  endtask

  task automatic check_cnt(input string name);
    @(negedge CLK);
    check({name, ".hit_cnt"},  bus.hit_cnt,  m_hits);
    check({name, ".miss_cnt"}, bus.miss_cnt, m_miss);
    @(posedge CLK); #1;
  endtask

  // Issue one fetch and hold it until ihit; data checked by the monitor.
  task automatic fetch(input logic [31:0] addr, input int lat);
    int idx, cyc, ren_cyc, exp_cyc;
    logic [25:0] tag;
    logic [31:0] al;
    logic exp_hit;
    al  = {addr[31:2], 2'b00};
    idx = int'(addr[5:2]);
    tag = addr[31:6];
    exp_hit = m_valid[idx] && (m_tag[idx] == tag);
    arb_lat = lat;
    if (exp_hit) begin
      exp_cyc = 0;
    end else begin
      exp_cyc = lat + 2;
      m_miss++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_data[idx]  = mem_word(al);
    end
    m_hits++;
    exp_q.push_back(m_data[idx]);
    exp_fill_addr = al;
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    cyc = 0;
    ren_cyc = 0;
    forever begin
      @(negedge CLK);
      if (bus.ihit) break;
      if (bus.iREN) ren_cyc++;
      cyc++;
      if (cyc > 100) begin
        check("fetch_timeout", 32'(cyc), 32'(exp_cyc));
        break;
      end
      @(posedge CLK); #1;
    end
    check("fetch_latency", 32'(cyc), 32'(exp_cyc));
    if (!exp_hit) check("iren_cycles", 32'(ren_cyc), 32'(lat + 1));
    @(posedge CLK); #1;
    bus.imemREN = 1'b0;
  endtask

  // Monitor: every ihit must match the oldest outstanding expected word.
  always @(negedge CLK) begin
    if (nRST && bus.ihit) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_hit: got ihit=1 data=0x%08h, required no hit", bus.imemload);
      end else begin
        check("imemload", bus.imemload, exp_q.pop_front());
      end
    end
  end

  // Arbiter: arb_lat busy cycles then one data cycle; checks the held fill address.
  always @(negedge CLK) begin
    if (nRST && bus.iREN) begin
      check("iaddr", bus.iaddr, exp_fill_addr);
      if (wcnt < arb_lat) begin
        bus.iwait = 1'b1;
        wcnt++;
      end else begin
        bus.iwait = 1'b0;
        bus.iload = mem_word(bus.iaddr);
        wcnt = 0;
      end
    end else begin
      bus.iwait = 1'b1;
      bus.iload = 32'hDEAD_BEEF;
      wcnt = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    nRST = 1'b0;
    bus.imemREN = 1'b0;
    bus.imemaddr = '0;
    bus.iwait = 1'b1;
    bus.iload = '0;
    arb_lat = 0;
    wcnt = 0;
    exp_fill_addr = '0;
    model_reset();
    mem[32'h0000_0004] = 32'h2008_0001;
    mem[32'h0000_0000] = 32'hAAAA_AAAA;
    mem[32'h0000_0040] = 32'hBBBB_BBBB;
    mem[32'h0000_0008] = 32'h1234_5678;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("rst.ihit", 32'(bus.ihit), 32'd0);
    check("rst.iREN", 32'(bus.iREN), 32'd0);
    check("rst.iaddr", bus.iaddr, 32'd0);
    check("rst.imemload", bus.imemload, 32'd0);
    check("rst.hit_cnt", bus.hit_cnt, 32'd0);
    check("rst.miss_cnt", bus.miss_cnt, 32'd0);
    @(posedge CLK); #1;

    // Cold miss then hit
    fetch(32'h0000_0004, 3);
    check_cnt("cold");
    check("cold.miss_is_1", bus.miss_cnt, 32'd1);

    // Conflict eviction
    do_reset();
    fetch(32'h0000_0000, 1);
    fetch(32'h0000_0040, 2);
    fetch(32'h0000_0000, 1);
    check_cnt("conflict");
    check("conflict.miss_is_3", bus.miss_cnt, 32'd3);

    // Independent frames
    do_reset();
    for (int i = 0; i < 16; i++) fetch(32'(i * 4), i % 3);
    for (int i = 0; i < 16; i++) fetch(32'(i * 4), 0);
    check_cnt("frames");

    // Request drop mid-fill
    do_reset();
    arb_lat = 2;
    exp_fill_addr = 32'h0000_0008;
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h0000_0008;
    @(posedge CLK); #1;
    bus.imemREN = 1'b0;
    bus.imemaddr = 32'hFFFF_FFF0;
    m_miss++;
    m_valid[2] = 1'b1;
    m_tag[2] = 26'd0;
    m_data[2] = 32'h1234_5678;
    repeat (5) @(posedge CLK);
    #1;
    fetch(32'h0000_0008, 0);
    check_cnt("drop");

    // Reset mid-LD
    do_reset();
    arb_lat = 8;
    exp_fill_addr = 32'h0000_000C;
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h0000_000C;
    @(posedge CLK); #1;
    bus.imemREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    model_reset();
    @(negedge CLK);
    check("rstld.iREN", 32'(bus.iREN), 32'd0);
    check("rstld.hit_cnt", bus.hit_cnt, 32'd0);
    check("rstld.miss_cnt", bus.miss_cnt, 32'd0);
    @(posedge CLK); #1;
    fetch(32'h0000_000C, 1);
    check_cnt("rstld");

    // Byte-offset ignore
    do_reset();
    fetch(32'h0000_0010, 1);
    fetch(32'h0000_0013, 0);
    check_cnt("byteofs");

    // Random traffic over a few tags that alias onto the same frames
    do_reset();
    for (int n = 0; n < 300; n++) begin
      a = ($urandom & 32'h0000_00FF) | (32'($urandom_range(0, 1)) << 20);
      fetch(a, int'($urandom_range(0, 4)));
      if ($urandom_range(0, 3) == 0) @(posedge CLK);
      #1;
    end
    check_cnt("random");

    repeat (3) @(posedge CLK);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
